// File: rtl/wb_arbiter_pkg.sv
// Shared write-back types and widths.
// Imported by the write-back arbiter and its per-source FIFO.
package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Per-source write-back FIFO (module wb_fifo).
// Exposes per-entry valid/rd so the top can build the pending-rd mask.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  wb_req_t                       din,
  output wb_req_t                       dout,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0]              ent_vld,
  output logic [DEPTH*REG_ADDR_W-1:0]   ent_rd
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  wb_req_t     r_mem [DEPTH];
  logic [AW:0] w_cnt;
  logic [AW-1:0] w_off;

  assign w_cnt = r_wptr - r_rptr;
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                 (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign dout  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push && !full)  r_wptr <= r_wptr + PTR_ONE;
      if (pop  && !empty) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) r_mem[r_wptr[AW-1:0]] <= din;
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    ent_vld = '0;
    ent_rd  = '0;
    w_off   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_off = AW'(j) - r_rptr[AW-1:0];
      ent_vld[j] = ({1'b0, w_off} < w_cnt);
      ent_rd[j*REG_ADDR_W +: REG_ADDR_W] = r_mem[j].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter feeding the register-file write port.
// Define WB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SRC-1:0]              src_valid,
  output logic [N_SRC-1:0]              src_ready,
  input  logic [N_SRC*REG_ADDR_W-1:0]   src_rd,
  input  logic [N_SRC*XLEN-1:0]         src_data,
  output logic                          w_enable,
  output logic [REG_ADDR_W-1:0]         w_addr,
  output logic [XLEN-1:0]               w_data,
  output logic [31:0]                   pend_mask
);

  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] w_push;
  logic [N_SRC-1:0] w_pop;
  logic [N_SRC-1:0] w_full;
  logic [N_SRC-1:0] w_empty;
  wb_req_t          w_din  [N_SRC];
  wb_req_t          w_dout [N_SRC];
  logic [DEPTH-1:0] w_vld  [N_SRC];
  logic [DEPTH*REG_ADDR_W-1:0] w_erd [N_SRC];

  logic             w_gnt_any;
  logic [SW-1:0]    w_gidx;
  wb_req_t          w_head;

  logic                  r_wen;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [XLEN-1:0]       r_wdata;

  assign src_ready = ~w_full & {N_SRC{~rst}};
  assign w_push    = src_valid & src_ready;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign w_din[g].rd   = src_rd[g*REG_ADDR_W +: REG_ADDR_W];
    assign w_din[g].data = src_data[g*XLEN +: XLEN];

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (w_push[g]),
      .pop     (w_pop[g]),
      .din     (w_din[g]),
      .dout    (w_dout[g]),
      .full    (w_full[g]),
      .empty   (w_empty[g]),
      .ent_vld (w_vld[g]),
      .ent_rd  (w_erd[g])
    );
  end

`ifdef WB_ROUND_ROBIN_EN
  logic [SW-1:0] r_rr;
  logic [SW-1:0] w_rr_nxt;

  always_comb begin : p_arb
    int idx;
    w_gnt_any = 1'b0;
    w_gidx    = '0;
    idx       = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(r_rr) + k) % N_SRC;
      if (!w_gnt_any && !w_empty[idx]) begin
        w_gnt_any = 1'b1;
        w_gidx    = SW'(idx);
      end
    end
    w_rr_nxt = (int'(w_gidx) == N_SRC-1) ? '0 : w_gidx + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_rr <= '0;
    else if (w_gnt_any) r_rr <= w_rr_nxt;
  end
`else
  always_comb begin : p_arb
    w_gnt_any = 1'b0;
    w_gidx    = '0;
    for (int k = N_SRC-1; k >= 0; k--) begin
      if (!w_empty[k]) begin
        w_gnt_any = 1'b1;
        w_gidx    = SW'(k);
      end
    end
  end
`endif

  always_comb begin
    w_pop = '0;
    if (w_gnt_any) w_pop[w_gidx] = 1'b1;
  end

  assign w_head = w_dout[w_gidx];

  // x0 results still take their slot but never strobe the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_gnt_any) begin
      r_wen   <= (w_head.rd != '0);
      r_waddr <= w_head.rd;
      r_wdata <= w_head.data;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  assign w_enable = r_wen;
  assign w_addr   = r_waddr;
  assign w_data   = r_wdata;

  always_comb begin
    pend_mask = '0;
    for (int s = 0; s < N_SRC; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_vld[s][e]) pend_mask[w_erd[s][e*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
      end
    end
    if (r_wen) pend_mask[r_waddr] = 1'b1;
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a per-source write scoreboard.
// Cross-source ordering is checked explicitly where it is defined.
module tb_wb_arbiter;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  v;
  logic [4:0]  rd_s  [3];
  logic [31:0] dat_s [3];
  logic [2:0]  src_ready;
  logic [14:0] src_rd;
  logic [95:0] src_data;
  logic        w_enable;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] pend_mask;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sbq [3][$];

  assign src_rd   = {rd_s[2], rd_s[1], rd_s[0]};
  assign src_data = {dat_s[2], dat_s[1], dat_s[0]};

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (v),
    .src_ready (src_ready),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .w_enable  (w_enable),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .pend_mask (pend_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    for (int s = 0; s < 3; s++)
      if (v[s] && src_ready[s] && rd_s[s] != 5'd0)
        sbq[s].push_back(exp_t'({rd_s[s], dat_s[s]}));
    @(posedge clk);
    #1;
  endtask

  function automatic int sb_left();
    return sbq[0].size() + sbq[1].size() + sbq[2].size();
  endfunction

  task automatic drain(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (sb_left() == 0) break;
      tick();
    end
    chk(tag, sb_left(), 0);
  endtask

  always @(negedge clk) begin
    bit hit;
    hit = 1'b0;
    if (!rst && w_enable) begin
      for (int s = 0; s < 3; s++) begin
        if (!hit && sbq[s].size() > 0 &&
            sbq[s][0].a === w_addr && sbq[s][0].d === w_data) begin
          hit = 1'b1;
          sbq[s].delete(0);
        end
      end
      n_vec++;
      assert (hit === 1'b1) else begin
        n_err++;
        $error("FAIL wb_write: observed rd=%0d data=%h expected a queued source head",
               w_addr, w_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ord [3];
    int n1, n6, bad;
    v = '0;
    for (int s = 0; s < 3; s++) begin
      rd_s[s]  = '0;
      dat_s[s] = '0;
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_wen",   32'(w_enable), 0);
    chk("rst_waddr", 32'(w_addr), 0);
    chk("rst_wdata", w_data, 0);
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_pmask", pend_mask, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rel_ready", 32'(src_ready), 32'h7);

    // single result from src0
    v[0] = 1'b1; rd_s[0] = 5'd5; dat_s[0] = 32'hDEADBEEF;
    tick();
    v = '0;
    chk("s_pm_buf", 32'(pend_mask[5]), 1);
    chk("s_wen0",   32'(w_enable), 0);
    tick();
    chk("s_wen",   32'(w_enable), 1);
    chk("s_addr",  32'(w_addr), 5);
    chk("s_data",  w_data, 32'hDEADBEEF);
    chk("s_pm_out", 32'(pend_mask[5]), 1);
    tick();
    chk("s_idle",  32'(w_enable), 0);
    chk("s_hold",  32'(w_addr), 5);
    chk("s_pm_clr", pend_mask, 0);

    // three-way contention
`ifdef WB_ROUND_ROBIN_EN
    ord[0] = 5'd2; ord[1] = 5'd3; ord[2] = 5'd1;
`else
    ord[0] = 5'd1; ord[1] = 5'd2; ord[2] = 5'd3;
`endif
    v = 3'b111;
    for (int s = 0; s < 3; s++) begin
      rd_s[s]  = 5'(s + 1);
      dat_s[s] = 32'h100 * (s + 1);
    end
    tick();
    v = '0;
    chk("c_pm", pend_mask, 32'hE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("c_wen",  32'(w_enable), 1);
      chk("c_addr", 32'(w_addr), 32'(ord[i]));
    end
    tick();
    chk("c_idle", 32'(w_enable), 0);

    // backpressure on src1 while src0 streams
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      v[0] = 1'b1; rd_s[0] = 5'd10; dat_s[0] = 32'h4000 + i;
      v[1] = (n1 < 3); rd_s[1] = 5'd11; dat_s[1] = 32'h1100 + n1;
`ifndef WB_ROUND_ROBIN_EN
      if (i == 2) chk("bp_ready1", 32'(src_ready[1]), 0);
`endif
      if (v[1] && src_ready[1]) n1++;
      tick();
    end
    v[0] = 1'b0;
    for (int i = 0; i < 20 && n1 < 3; i++) begin
      v[1] = 1'b1; dat_s[1] = 32'h1100 + n1;
      if (src_ready[1]) n1++;
      tick();
    end
    v = '0;
    chk("bp_accepts", n1, 3);
    drain("bp_drain");

    // x0 results consume grant slots silently
    v[2] = 1'b1; rd_s[2] = 5'd0; dat_s[2] = 32'hFFFFFFFF;
    tick();
    chk("x0_pm", pend_mask, 0);
    tick();
    v = '0;
    chk("x0_wen_a", 32'(w_enable), 0);
    chk("x0_pm_b",  pend_mask, 0);
    tick();
    chk("x0_wen_b", 32'(w_enable), 0);
    v[2] = 1'b1; rd_s[2] = 5'd7; dat_s[2] = 32'h77;
    tick();
    v = '0;
    tick();
    chk("x0_after", 32'(w_addr), 7);

    // ten pushes through src1 with interleaved pops
    n6 = 0;
    bad = 0;
    for (int c = 0; c < 40 && n6 < 10; c++) begin
      v[1] = (c % 3 != 2); rd_s[1] = 5'd12; dat_s[1] = 32'h6000 + n6;
      if (!src_ready[1]) bad++;
      if (v[1] && src_ready[1]) n6++;
      tick();
    end
    v = '0;
    chk("wrap_count", n6, 10);
    chk("wrap_ready", bad, 0);
    drain("wrap_drain");

    // reset in the middle of traffic
    v = 3'b111;
    for (int s = 0; s < 3; s++) begin
      rd_s[s]  = 5'(20 + s);
      dat_s[s] = 32'hA000 + s;
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    v = '0;
    for (int s = 0; s < 3; s++) sbq[s].delete();
    chk("mr_wen",   32'(w_enable), 0);
    chk("mr_waddr", 32'(w_addr), 0);
    chk("mr_wdata", w_data, 0);
    chk("mr_ready", 32'(src_ready), 0);
    chk("mr_pmask", pend_mask, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mr_rel_ready", 32'(src_ready), 32'h7);
    tick();
    tick();
    tick();
    chk("mr_nowrite", 32'(w_enable), 0);
    chk("mr_pm_post", pend_mask, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
